// File: rtl/if_id_fetch_stage.sv
`timescale 1ns/1ps
// MIPS instruction-fetch stage and IF/ID pipeline register, single outstanding imem read.
// Optional macro IF_BUBBLE_CNT_EN adds a saturating bubble_count output.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc_plus4
`ifdef IF_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {ISSUE, WAIT, FULL, DISCARD} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_buf, w_buf_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_pc_plus4, w_pc_plus4_next;
  logic        r_valid, w_valid_next;
  logic [31:0] w_pc_inc;
  logic [31:0] w_redirect_aligned;
  logic        w_slot_free;

  assign w_pc_inc           = r_pc + 32'd4;
  assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign w_slot_free        = !r_valid || id_ready;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_buf_next      = r_buf;
    w_instr_next    = r_instr;
    w_pc_plus4_next = r_pc_plus4;
    w_valid_next    = r_valid;

    // Consumed slot drains to a NOP unless a load below refills it.
    if (r_valid && id_ready) begin
      w_valid_next = 1'b0;
      w_instr_next = 32'd0;
    end

    unique case (r_state)
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          w_pc_next = w_pc_inc;
          if (w_slot_free) begin
            w_instr_next    = imem_rdata;
            w_pc_plus4_next = w_pc_inc;
            w_valid_next    = 1'b1;
            w_state_next    = ISSUE;
          end else begin
            w_buf_next   = imem_rdata;
            w_state_next = FULL;
          end
        end
      end
      FULL: begin
        // pc already advanced past the parked word, so it is that word's pc+4.
        if (w_slot_free) begin
          w_instr_next    = r_buf;
          w_pc_plus4_next = r_pc;
          w_valid_next    = 1'b1;
          w_buf_next      = 32'd0;
          w_state_next    = ISSUE;
        end
      end
      DISCARD: begin
        if (imem_rvalid) w_state_next = ISSUE;
      end
    endcase

    if (redirect_valid) begin
      w_pc_next       = w_redirect_aligned;
      w_valid_next    = 1'b0;
      w_instr_next    = 32'd0;
      w_pc_plus4_next = 32'd0;
      w_buf_next      = 32'd0;
      if (r_state == ISSUE ||
          ((r_state == WAIT || r_state == DISCARD) && !imem_rvalid))
        w_state_next = DISCARD;
      else
        w_state_next = ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ISSUE;
      r_pc       <= RESET_PC_ALIGNED;
      r_buf      <= 32'd0;
      r_instr    <= 32'd0;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_buf      <= w_buf_next;
      r_instr    <= w_instr_next;
      r_pc_plus4 <= w_pc_plus4_next;
      r_valid    <= w_valid_next;
    end
  end

  // Request is masked while reset is held so none escapes before release.
  assign imem_req    = rst_n && (r_state == ISSUE);
  assign imem_addr   = r_pc;
  assign id_valid    = r_valid;
  assign id_instr    = r_instr;
  assign id_opcode   = r_instr[31:26];
  assign id_pc_plus4 = r_pc_plus4;

`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] r_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bubble <= 32'd0;
    else if (redirect_valid)
      r_bubble <= 32'd0;
    else if (!r_valid && r_bubble != 32'hFFFF_FFFF)
      r_bubble <= r_bubble + 32'd1;
  end

  assign bubble_count = r_bubble;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for if_id_fetch_stage: fetch addresses and accepted IF/ID words are
// queued by the stimulus and popped by independent monitors.
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_rvalid, redirect_valid, id_ready, id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc_plus4;
  logic [5:0]  id_opcode;

  logic        rst_b_n = 1'b1;
  logic        imem_req_b, imem_rvalid_b, id_valid_b;
  logic [31:0] imem_addr_b, imem_rdata_b, id_instr_b, id_pc_plus4_b;
  logic [5:0]  id_opcode_b;
  logic        redirect_valid_b = 1'b0;
  logic [31:0] redirect_pc_b = 32'd0;
  logic        id_ready_b = 1'b1;
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_a, bubble_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;

  logic [31:0] exp_fetch[$];
  logic [63:0] exp_id[$];

  always #5 clk = ~clk;

  if_id_fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_pc_plus4(id_pc_plus4)
`ifdef IF_BUBBLE_CNT_EN
    , .bubble_count(bubble_a)
`endif
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_rvalid(imem_rvalid_b), .imem_rdata(imem_rdata_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .id_ready(id_ready_b), .id_valid(id_valid_b), .id_instr(id_instr_b),
    .id_opcode(id_opcode_b), .id_pc_plus4(id_pc_plus4_b)
`ifdef IF_BUBBLE_CNT_EN
    , .bubble_count(bubble_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", nm, act);
    end
  endtask

  function automatic logic [31:0] word_a(input logic [31:0] a);
    return (a == 32'd0) ? 32'h8C08_0004 : (32'h2000_0000 | a);
  endfunction

  // Memory A: answers each request after mem_lat cycles, latency captured at request time.
  initial begin
    int cnt;
    logic [31:0] addr;
    cnt = 0; addr = 0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_a(addr);
        end
      end
      if (imem_req === 1'b1) begin
        cnt  = mem_lat;
        addr = imem_addr;
      end
    end
  end

  // Memory B: fixed one-cycle latency, constant J-type word.
  initial begin
    int cnt;
    cnt = 0;
    imem_rvalid_b = 1'b0; imem_rdata_b = 32'd0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid_b = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_b = 1'b1;
          imem_rdata_b  = 32'h0800_0010;
        end
      end
      if (imem_req_b === 1'b1) cnt = 1;
    end
  end

  // Fetch monitor.
  initial forever begin
    @(negedge clk); #1;
    if (rst_n === 1'b1 && imem_req === 1'b1) begin
      if (exp_fetch.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL fetch_unexpected actual=%h expected=none", imem_addr);
      end else begin
        chk("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
    end
  end

  // IF/ID acceptance monitor.
  initial forever begin
    logic [63:0] e;
    @(negedge clk); #1;
    if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
      if (exp_id.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL id_unexpected actual=%h expected=none", id_instr);
      end else begin
        e = exp_id.pop_front();
        chk("id_instr", id_instr, e[63:32]);
        chk("id_pc_plus4", id_pc_plus4, e[31:0]);
        chk("id_opcode", {26'd0, id_opcode}, {26'd0, e[63:58]});
      end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_instr"}, id_instr, 32'd0);
    chk({tag, "_pc4"}, id_pc_plus4, 32'd0);
    chk({tag, "_opcode"}, {26'd0, id_opcode}, 32'd0);
  endtask

  initial begin
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #1 rst_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 chk_reset_a("rst");

    exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8);
    exp_id.push_back({32'h8C08_0004, 32'h4});
    exp_id.push_back({32'h2000_0004, 32'h8});

    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk); #2;
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("first_opcode", {26'd0, id_opcode}, 32'd35);
    chk("first_pc4", id_pc_plus4, 32'h4);
    @(negedge clk); #2 chk("wait_no_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("full_valid", {31'd0, id_valid}, 32'd1);
      chk("full_instr_stable", id_instr, 32'h8C08_0004);
      chk("full_no_req", {31'd0, imem_req}, 32'd0);
    end
    @(negedge clk); id_ready = 1'b1;
    @(negedge clk); #2;
    chk("unpark_instr", id_instr, 32'h2000_0004);
    chk("unpark_pc4", id_pc_plus4, 32'h8);

    exp_fetch.push_back(32'hC); exp_fetch.push_back(32'h100);
    exp_fetch.push_back(32'h200); exp_fetch.push_back(32'h204);

    @(negedge clk); mem_lat = 2;
    @(negedge clk); id_ready = 1'b0; #2;
    chk("held_instr", id_instr, 32'h2000_0008);
    chk("held_pc4", id_pc_plus4, 32'hC);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk); redirect_valid = 1'b0; #2;
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_instr", id_instr, 32'd0);
    chk("redir_pc4", id_pc_plus4, 32'd0);
    @(negedge clk); #2 chk("stale_dropped", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk); redirect_valid = 1'b0; mem_lat = 1; #2;
    chk("coinc_valid", {31'd0, id_valid}, 32'd0);
    chk("coinc_instr", id_instr, 32'd0);
    @(negedge clk);
    @(negedge clk); mem_lat = 2; #2;
    chk("target_instr", id_instr, 32'h2000_0200);
    chk("target_pc4", id_pc_plus4, 32'h204);
    @(negedge clk); rst_n = 1'b0; #2;
    chk_reset_a("async_rst");

    exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8);
    exp_id.push_back({32'h8C08_0004, 32'h4});
    exp_id.push_back({32'h2000_0004, 32'h8});

    @(negedge clk); mem_lat = 1; rst_n = 1'b1; #2;
    chk("late_rvalid_ign0", {31'd0, id_valid}, 32'd0);
    @(negedge clk); #2 chk("late_rvalid_ign1", {31'd0, id_valid}, 32'd0);
    @(negedge clk); id_ready = 1'b1; #2;
    chk("restart_valid", {31'd0, id_valid}, 32'd1);
    chk("restart_pc4", id_pc_plus4, 32'h4);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #2;
    chk("fetch_queue_empty", exp_fetch.size(), 32'd0);
    chk("id_queue_empty", exp_id.size(), 32'd0);

    @(negedge clk); rst_b_n = 1'b1; #2;
    chk("wrap_first_req", {31'd0, imem_req_b}, 32'd1);
    chk("wrap_first_addr", imem_addr_b, 32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk); #2;
    chk("wrap_valid", {31'd0, id_valid_b}, 32'd1);
    chk("wrap_instr", id_instr_b, 32'h0800_0010);
    chk("wrap_opcode", {26'd0, id_opcode_b}, 32'd2);
    chk("wrap_pc4", id_pc_plus4_b, 32'h0);
    chk("wrap_second_req", {31'd0, imem_req_b}, 32'd1);
    chk("wrap_second_addr", imem_addr_b, 32'h0);
`ifdef IF_BUBBLE_CNT_EN
    chk("bubble_count", bubble_b, 32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS core.
- Owns the PC and issues single-outstanding reads to instruction memory.
- Holds each fetched word in the IF/ID register; the register drives id_opcode straight into the main control decoder.
- Supports decode back-pressure (id_ready) and a redirect port from branch/jump resolution that flushes the IF/ID register and any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request strobe, one cycle per request
imem_addr  output  32  word-aligned fetch address, valid while imem_req=1
imem_rvalid  input  1  response strobe, ≥1 cycle after imem_req, exactly one per request
imem_rdata  input  32  instruction word, valid with imem_rvalid
redirect_valid  input  1  branch taken / jump: restart fetch at redirect_pc
redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0)
id_ready  input  1  decode accepts the IF/ID contents this cycle
id_valid  output  1  IF/ID register holds a live instruction
id_instr  output  32  IF/ID instruction word
id_opcode  output  6  id_instr[31:26], combinational from register, feeds control decoder
id_pc_plus4  output  32  address of the held instruction + 4, for JAL link / branch target

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=ISSUE, imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_instr=0, id_pc_plus4=0, hold buffer empty.
- States:
  - ISSUE: imem_req=1, imem_addr=pc, go WAIT next cycle.
  - WAIT: imem_req=0; stay until imem_rvalid.
  - FULL: response parked in hold buffer; no request issued.
  - DISCARD: in-flight response must be dropped.
- Slot free = (id_valid=0) or (id_valid=1 and id_ready=1).
- WAIT + imem_rvalid, slot free: id_instr<=imem_rdata, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4, go ISSUE.
- WAIT + imem_rvalid, slot not free: buffer<=imem_rdata, pc<=pc+4, go FULL.
- FULL, slot free: IF/ID<=buffer (id_pc_plus4 = address of buffered instruction + 4), id_valid<=1, go ISSUE.
- Consumed with nothing new: id_valid=1, id_ready=1 and no load this cycle -> id_valid<=0, id_instr<=0 (NOP).
- Redirect (highest priority, any state): pc<={redirect_pc[31:2],2'b00}, id_valid<=0, id_instr<=0, id_pc_plus4<=0, buffer cleared.
  - Next state DISCARD if a request is outstanding and not answered this cycle (WAIT without rvalid, DISCARD without rvalid, or ISSUE).
  - Otherwise next state ISSUE.
  - Redirect coincident with rvalid in WAIT: data dropped, go ISSUE.
- DISCARD + imem_rvalid: drop data, go ISSUE. Redirect in DISCARD only updates pc.
- pc+4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 0, no flag.
- Latency: first imem_req in the first cycle after rst_n deasserts. id_valid rises the cycle after imem_rvalid.
- Throughput: 1 instruction per 2 cycles with 1-cycle memory.
- imem_addr[1:0] is always 0. Never more than one request outstanding.

Optional Feature:
IF_BUBBLE_CNT_EN
- Defined: adds output bubble_count[31:0], reset 0, +1 on each cycle with id_valid=0, saturates at 32'hFFFF_FFFF, also cleared by redirect_valid.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, memory answers 1 cycle after req with 32'h8C08_0004: imem_addr=0 on cycle 1; id_valid=1, id_opcode=6'd35, id_pc_plus4=4 two cycles later; next req addr 4.
- id_ready=0 for 5 cycles with 1-cycle memory: second word parked (FULL), no third req, id_instr stable; on id_ready=1 second word appears, pc_plus4=8, next req addr 8.
- redirect_valid with redirect_pc=32'h0000_0103 while in WAIT, rvalid 2 cycles later: id_valid=0 and id_instr=0 same edge, stale data dropped, next req addr 32'h0000_0100.
- redirect_valid coincident with imem_rvalid: data never reaches IF/ID; next req at redirect target.
- rst_n pulsed low mid-WAIT: all outputs at reset values immediately (async); late rvalid ignored; fetch restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFFC: second req addr 32'h0000_0000 (wrap); with IF_BUBBLE_CNT_EN, bubble_count=2 at first id_valid.
